// File: rtl/vend_pkg.sv
// Shared vending definitions: coin indices, coin values and payout states.
// The coin-in accumulator uses the same coin encoding and values.
package vend_pkg;

    localparam int AMOUNT_W_DFLT = 9;

    localparam int VAL_P = 1;
    localparam int VAL_N = 5;
    localparam int VAL_D = 10;
    localparam int VAL_Q = 25;

    typedef enum logic [1:0] {
        COIN_P = 2'd0,
        COIN_N = 2'd1,
        COIN_D = 2'd2,
        COIN_Q = 2'd3
    } coin_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_WAIT_ACK,
        ST_DONE
    } payout_state_e;

    function automatic logic [4:0] coin_value(coin_e c);
        logic [4:0] v;
        unique case (c)
            COIN_Q:  v = 5'(VAL_Q);
            COIN_D:  v = 5'(VAL_D);
            COIN_N:  v = 5'(VAL_N);
            default: v = 5'(VAL_P);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_payout_if.sv
// Payout bus: change request handshake, hopper control and result reporting.
// master = request/hopper side, slave = payout sequencer.
interface change_payout_if
    import vend_pkg::*;
#(
    parameter int AMOUNT_W = AMOUNT_W_DFLT
) ();

    logic                req_valid;
    logic [AMOUNT_W-1:0] req_amount;
    logic                req_ready;
    logic [3:0]          hopper_empty;
    logic                hopper_ack;
    logic [3:0]          eject;
    logic                busy;
    logic                done;
    logic [AMOUNT_W-1:0] paid_amount;
    logic [AMOUNT_W-1:0] short_amount;

    modport master (
        output req_valid, req_amount, hopper_empty, hopper_ack,
        input  req_ready, eject, busy, done, paid_amount, short_amount
    );

    modport slave (
        input  req_valid, req_amount, hopper_empty, hopper_ack,
        output req_ready, eject, busy, done, paid_amount, short_amount
    );

endinterface

// File: rtl/payout_timer.sv
// Loadable down-counter shared by the eject-pulse and ack-timeout phases.
// expired is high whenever the count has reached zero.
module payout_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // load wins; otherwise count down and stick at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/change_payout.sv
// Coin-out sequencer: greedy coin choice, one eject pulse per coin,
// ack handshake with timeout, empty/failed hopper fallback.
module change_payout
    import vend_pkg::*;
#(
    parameter int AMOUNT_W     = AMOUNT_W_DFLT,
    parameter int PULSE_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    change_payout_if.slave       bus
);

    localparam int TMAX = (PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    payout_state_e       state_q, state_d;
    coin_e               coin_q, coin_d;
    logic [AMOUNT_W-1:0] remaining_q, remaining_d;
    logic [AMOUNT_W-1:0] paid_q, paid_d;
    logic [AMOUNT_W-1:0] short_q, short_d;
    logic [3:0]          fail_q, fail_d;
    logic                ack_seen_q, ack_seen_d;
    logic [3:0]          eject_q, eject_d;

    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic                tmr_expired;
    logic [3:0]          elig;
    logic [AMOUNT_W-1:0] coin_val;

    payout_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    assign coin_val = AMOUNT_W'(coin_value(coin_q));

    assign elig[COIN_Q] = (remaining_q >= AMOUNT_W'(VAL_Q)) &&
                          !bus.hopper_empty[COIN_Q] && !fail_q[COIN_Q];
    assign elig[COIN_D] = (remaining_q >= AMOUNT_W'(VAL_D)) &&
                          !bus.hopper_empty[COIN_D] && !fail_q[COIN_D];
    assign elig[COIN_N] = (remaining_q >= AMOUNT_W'(VAL_N)) &&
                          !bus.hopper_empty[COIN_N] && !fail_q[COIN_N];
    assign elig[COIN_P] = (remaining_q >= AMOUNT_W'(VAL_P)) &&
                          !bus.hopper_empty[COIN_P] && !fail_q[COIN_P];

    // next-state, datapath update and eject/timer control
    always_comb begin
        state_d     = state_q;
        coin_d      = coin_q;
        remaining_d = remaining_q;
        paid_d      = paid_q;
        short_d     = short_q;
        fail_d      = fail_q;
        ack_seen_d  = ack_seen_q;
        eject_d     = '0;
        tmr_load    = 1'b0;
        tmr_val     = TW'(PULSE_CYCLES);
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    remaining_d = bus.req_amount;
                    paid_d      = '0;
                    short_d     = '0;
                    fail_d      = '0;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (|elig) begin
                    state_d    = ST_EJECT;
                    ack_seen_d = 1'b0;
                    tmr_load   = 1'b1;
                    if (elig[COIN_Q]) begin
                        coin_d = COIN_Q;
                    end else if (elig[COIN_D]) begin
                        coin_d = COIN_D;
                    end else if (elig[COIN_N]) begin
                        coin_d = COIN_N;
                    end else begin
                        coin_d = COIN_P;
                    end
                end else begin
                    short_d = remaining_q;
                    state_d = ST_DONE;
                end
            end
            ST_EJECT: begin
                // the first EJECT cycle sets up the pulse, so eject stays
                // high for exactly PULSE_CYCLES cycles and never outside EJECT
                if (bus.hopper_ack) begin
                    ack_seen_d = 1'b1;
                end
                if (!tmr_expired) begin
                    eject_d = 4'b0001 << coin_q;
                end else if (ack_seen_q || bus.hopper_ack) begin
                    remaining_d = remaining_q - coin_val;
                    paid_d      = paid_q + coin_val;
                    state_d     = ST_SELECT;
                end else begin
                    state_d  = ST_WAIT_ACK;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(ACK_TIMEOUT);
                end
            end
            ST_WAIT_ACK: begin
                if (bus.hopper_ack) begin
                    remaining_d = remaining_q - coin_val;
                    paid_d      = paid_q + coin_val;
                    state_d     = ST_SELECT;
                end else if (tmr_expired) begin
                    fail_d[coin_q] = 1'b1;
                    state_d        = ST_SELECT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and datapath registers; reset aborts any transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            coin_q      <= COIN_P;
            remaining_q <= '0;
            paid_q      <= '0;
            short_q     <= '0;
            fail_q      <= '0;
            ack_seen_q  <= 1'b0;
            eject_q     <= '0;
        end else begin
            state_q     <= state_d;
            coin_q      <= coin_d;
            remaining_q <= remaining_d;
            paid_q      <= paid_d;
            short_q     <= short_d;
            fail_q      <= fail_d;
            ack_seen_q  <= ack_seen_d;
            eject_q     <= eject_d;
        end
    end

    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.eject        = eject_q;
    assign bus.paid_amount  = paid_q;
    assign bus.short_amount = short_q;

endmodule

// File: tb/tb_change_payout.sv
// Scoreboard bench for change_payout: directed requests, hopper responder,
// monitor comparing ejected coins and done results against expected queues.
module tb_change_payout;
    import vend_pkg::*;

    localparam int AW = 9;
    localparam int PC = 4;
    localparam int AT = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    change_payout_if #(.AMOUNT_W(AW)) bus ();

    change_payout #(
        .AMOUNT_W     (AW),
        .PULSE_CYCLES (PC),
        .ACK_TIMEOUT  (AT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    int exp_coin[$];
    int exp_paid[$];
    int exp_short[$];

    int no_ack_coin = -1;
    int rst_gen = 0;

    logic [3:0] prev_ej = '0;
    int width = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge rst_n) rst_gen++;

    // monitor: pulse shape, coin order and done results
    always @(negedge clk) begin
        prev_ej <= bus.eject;
        if (!rst_n) begin
            width <= 0;
        end else begin
            if (bus.eject != 0) begin
                width <= width + 1;
            end else if (prev_ej != 0) begin
                check("pulse_width", width, PC);
                width <= 0;
            end
            if (bus.eject != 0 && prev_ej == 0) begin
                check("eject_onehot", $countones(bus.eject), 1);
                if (exp_coin.size() == 0) begin
                    check("eject_unexpected", int'(bus.eject), 0);
                end else begin
                    int e;
                    e = exp_coin.pop_front();
                    check("eject_coin", int'(bus.eject), 1 << e);
                end
            end
            if (bus.done) begin
                if (exp_paid.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    check("paid_amount", int'(bus.paid_amount), exp_paid.pop_front());
                    check("short_amount", int'(bus.short_amount), exp_short.pop_front());
                end
            end
        end
    end

    // hopper responder: ack 3 cycles after each pulse ends
    initial begin
        bus.hopper_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.eject != 0) begin
                int c;
                int g;
                int n;
                c = 0;
                for (int i = 0; i < 4; i++) begin
                    if (bus.eject[i]) c = i;
                end
                g = rst_gen;
                n = 0;
                while (bus.eject != 0 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (g == rst_gen && rst_n && c != no_ack_coin) begin
                    repeat (3) @(negedge clk);
                    if (g == rst_gen) begin
                        bus.hopper_ack = 1'b1;
                        @(negedge clk);
                        bus.hopper_ack = 1'b0;
                    end
                end
            end
        end
    end

    // issue one request; report cycle index of done and first eject
    // (cycle 0 is the cycle in which the request is accepted)
    task automatic run_req(input int amt, input int budget,
                           output int done_cyc, output int ej_cyc);
        int n;
        done_cyc = -1;
        ej_cyc = -1;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 0, 1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_amount = AW'(amt);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.done && n < budget) begin
            if (bus.eject != 0 && ej_cyc < 0) ej_cyc = n;
            @(negedge clk);
            n++;
        end
        if (bus.done) begin
            done_cyc = n;
        end else begin
            check("done_timeout", 0, 1);
        end
    endtask

    initial begin
        int dc;
        int ec;
        int n;
        bus.req_valid = 1'b0;
        bus.req_amount = '0;
        bus.hopper_empty = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_req_ready", int'(bus.req_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_eject", int'(bus.eject), 0);
        check("rst_paid", int'(bus.paid_amount), 0);
        check("rst_short", int'(bus.short_amount), 0);
        rst_n = 1'b1;

        // 65 cents, all hoppers full
        exp_coin.push_back(COIN_Q);
        exp_coin.push_back(COIN_Q);
        exp_coin.push_back(COIN_D);
        exp_coin.push_back(COIN_N);
        exp_paid.push_back(65);
        exp_short.push_back(0);
        run_req(65, 500, dc, ec);
        check("first_eject_cycle", ec, 3);

        // zero amount
        exp_paid.push_back(0);
        exp_short.push_back(0);
        run_req(0, 50, dc, ec);
        check("zero_done_cycle", dc, 2);
        check("zero_no_eject", ec, -1);

        // quarters empty
        bus.hopper_empty = 4'b1000;
        repeat (3) exp_coin.push_back(COIN_D);
        exp_paid.push_back(30);
        exp_short.push_back(0);
        run_req(30, 500, dc, ec);

        // nickel and penny empty: nothing fits
        bus.hopper_empty = 4'b0011;
        exp_paid.push_back(0);
        exp_short.push_back(7);
        run_req(7, 50, dc, ec);
        check("short_no_eject", ec, -1);

        // quarter hopper never acks
        bus.hopper_empty = 4'b0000;
        no_ack_coin = COIN_Q;
        exp_coin.push_back(COIN_Q);
        exp_coin.push_back(COIN_D);
        exp_coin.push_back(COIN_D);
        exp_coin.push_back(COIN_N);
        exp_paid.push_back(25);
        exp_short.push_back(0);
        run_req(25, 500, dc, ec);
        check("timeout_total_cycles_min", int'(dc > PC + AT), 1);
        no_ack_coin = -1;

        // reset during the first eject of a 40-cent request
        exp_coin.push_back(COIN_Q);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_amount = AW'(40);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.eject == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_eject_seen", int'(bus.eject), 8);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_eject_low", int'(bus.eject), 0);
        check("abort_req_ready", int'(bus.req_ready), 1);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_paid", int'(bus.paid_amount), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        exp_coin.push_back(COIN_D);
        exp_paid.push_back(10);
        exp_short.push_back(0);
        run_req(10, 200, dc, ec);

        repeat (10) @(negedge clk);
        check("coin_queue_drained", exp_coin.size(), 0);
        check("result_queue_drained", exp_paid.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
